bus_arbiter: RTL and testbench

//  Two-master, one-slave arbiter for the 6502-style system bus. Master 0 is the
//  CPU bus port; master 1 is a secondary requester (OAM DMA / debug loader).

---
 rtl/bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master, one-slave system bus arbiter that runs one transaction at a time (IDLE -> BUSY -> DONE).
// Optional macro BUS_ARBITER_TIMEOUT_EN aborts a BUSY phase after TIMEOUT_CYCLES with error_o.
module bus_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] m0_address_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    input  logic                  m0_read_i,
    input  logic                  m0_write_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    input  logic [ADDR_WIDTH-1:0] m1_address_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    input  logic                  m1_read_i,
    input  logic                  m1_write_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  bus_read_o,
    output logic                  bus_write_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  bus_owner_o,
    output logic                  bus_busy_o,
    output logic                  error_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] m0_data_q, m0_data_d;
    logic [DATA_WIDTH-1:0] m1_data_q, m1_data_d;
    logic                  m0_ack_q, m0_ack_d;
    logic                  m1_ack_q, m1_ack_d;

    logic                  m0_req, m1_req;
    logic                  grant_m1;
    logic                  sel_read, sel_write;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] ack_data;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 7) ? $clog2(TIMEOUT_CYCLES) : 7;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             error_q, error_d;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        read_d       = read_q;
        write_d      = write_q;
        m0_data_d    = m0_data_q;
        m1_data_d    = m1_data_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        ack_data     = '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        error_d      = 1'b0;
        timed_out    = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
        timed_out    = 1'b0;
`endif

        m0_req = m0_read_i | m0_write_i;
        m1_req = m1_read_i | m1_write_i;
        // On a tie the master that did not win last time goes first, unless m0 is pinned.
        if (m0_req && m1_req) begin
            grant_m1 = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            grant_m1 = m1_req;
        end
        sel_write = grant_m1 ? m1_write_i : m0_write_i;
        sel_read  = (grant_m1 ? m1_read_i : m0_read_i) & ~sel_write;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d      = BUSY;
                    owner_d      = grant_m1;
                    last_grant_d = grant_m1;
                    address_d    = grant_m1 ? m1_address_i : m0_address_i;
                    wdata_d      = grant_m1 ? m1_data_i : m0_data_i;
                    read_d       = sel_read;
                    write_d      = sel_write;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    tmo_cnt_d    = '0;
`endif
                end
            end
            BUSY: begin
                if (data_valid_i || timed_out) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (data_valid_i) begin
                        ack_data = write_q ? '0 : data_i;
                    end else begin
                        ack_data = '1;
                    end
                    if (owner_q) begin
                        m1_ack_d  = 1'b1;
                        m1_data_d = ack_data;
                    end else begin
                        m0_ack_d  = 1'b1;
                        m0_data_d = ack_data;
                    end
`ifdef BUS_ARBITER_TIMEOUT_EN
                    error_d = ~data_valid_i;
`endif
                end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // last_grant resets to 1 so master 0 wins the first tie after reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            address_q    <= '0;
            wdata_q      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            m0_data_q    <= '0;
            m1_data_q    <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            read_q       <= read_d;
            write_q      <= write_d;
            m0_data_q    <= m0_data_d;
            m1_data_q    <= m1_data_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            error_q      <= error_d;
`endif
        end
    end

    assign m0_data_o   = m0_data_q;
    assign m0_ack_o    = m0_ack_q;
    assign m1_data_o   = m1_data_q;
    assign m1_ack_o    = m1_ack_q;
    assign address_o   = address_q;
    assign data_o      = wdata_q;
    assign bus_read_o  = read_q;
    assign bus_write_o = write_q;
    assign bus_owner_o = owner_q;
    assign bus_busy_o  = (state_q != IDLE);
`ifdef BUS_ARBITER_TIMEOUT_EN
    assign error_o     = error_q;
`else
    assign error_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter: a round-robin instance for the vector table and reset cases,
// plus a fixed-priority instance for the pinned-m0 ordering case.
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [15:0] m0_address = '0, m1_address = '0;
    logic [7:0]  m0_wdata = '0, m1_wdata = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [15:0] address;
    logic [7:0]  slave_wdata;
    logic        bus_read, bus_write;
    logic [7:0]  slave_rdata = '0;
    logic        data_valid = 1'b0;
    logic        owner, busy, error;

    logic        f_m0_read = 1'b0, f_m1_read = 1'b0;
    logic [7:0]  f_m0_rdata, f_m1_rdata;
    logic        f_m0_ack, f_m1_ack;
    logic [15:0] f_address;
    logic [7:0]  f_wdata;
    logic        f_bus_read, f_bus_write, f_data_valid;
    logic        f_owner, f_busy, f_error;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut (
        .clock_i(clock), .reset_i(reset),
        .m0_address_i(m0_address), .m0_data_i(m0_wdata), .m0_read_i(m0_read), .m0_write_i(m0_write),
        .m0_data_o(m0_rdata), .m0_ack_o(m0_ack),
        .m1_address_i(m1_address), .m1_data_i(m1_wdata), .m1_read_i(m1_read), .m1_write_i(m1_write),
        .m1_data_o(m1_rdata), .m1_ack_o(m1_ack),
        .address_o(address), .data_o(slave_wdata), .bus_read_o(bus_read), .bus_write_o(bus_write),
        .data_i(slave_rdata), .data_valid_i(data_valid),
        .bus_owner_o(owner), .bus_busy_o(busy), .error_o(error)
    );

    // The fixed-priority slave answers in the same cycle the strobe rises.
    assign f_data_valid = f_bus_read | f_bus_write;

    bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FIXED_PRIORITY(1), .TIMEOUT_CYCLES(64)) dut_fixed (
        .clock_i(clock), .reset_i(reset),
        .m0_address_i(16'h0100), .m0_data_i(8'h00), .m0_read_i(f_m0_read), .m0_write_i(1'b0),
        .m0_data_o(f_m0_rdata), .m0_ack_o(f_m0_ack),
        .m1_address_i(16'h0101), .m1_data_i(8'h00), .m1_read_i(f_m1_read), .m1_write_i(1'b0),
        .m1_data_o(f_m1_rdata), .m1_ack_o(f_m1_ack),
        .address_o(f_address), .data_o(f_wdata), .bus_read_o(f_bus_read), .bus_write_o(f_bus_write),
        .data_i(8'h5A), .data_valid_i(f_data_valid),
        .bus_owner_o(f_owner), .bus_busy_o(f_busy), .error_o(f_error)
    );

    typedef struct {
        logic        m0_rd, m0_wr;
        logic [15:0] m0_addr;
        logic [7:0]  m0_wd;
        logic        m1_rd, m1_wr;
        logic [15:0] m1_addr;
        logic [7:0]  m1_wd;
        int          latency;
        logic [7:0]  slave_rd;
        logic        exp_owner, exp_wr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wd;
        int          exp_strobes;
        logic [7:0]  exp_mdata;
        logic        exp_err;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called on a falling edge while the arbiter is idle; returns on a falling edge in the following IDLE cycle.
    task automatic apply_stimulus(input int idx, input vec_t v);
        int  strobes = 0;
        bit  got_ack = 0;
        m0_read = v.m0_rd; m0_write = v.m0_wr; m0_address = v.m0_addr; m0_wdata = v.m0_wd;
        m1_read = v.m1_rd; m1_write = v.m1_wr; m1_address = v.m1_addr; m1_wdata = v.m1_wd;
        for (int cyc = 0; cyc < 64 && !got_ack; cyc++) begin
            @(negedge clock);
            data_valid = 1'b0;
            if (m0_ack || m1_ack) begin
                got_ack = 1;
                check_output($sformatf("v%0d_ack_winner", idx), v.exp_owner ? m1_ack : m0_ack, 1);
                check_output($sformatf("v%0d_ack_other", idx), v.exp_owner ? m0_ack : m1_ack, 0);
                check_output($sformatf("v%0d_ack_data", idx), v.exp_owner ? m1_rdata : m0_rdata, v.exp_mdata);
                check_output($sformatf("v%0d_error", idx), error, v.exp_err);
                check_output($sformatf("v%0d_strobe_cycles", idx), strobes, v.exp_strobes);
                check_output($sformatf("v%0d_strobes_dropped", idx), {bus_read, bus_write}, 0);
                check_output($sformatf("v%0d_busy_done", idx), busy, 1);
                if (v.exp_owner) begin m1_read = 1'b0; m1_write = 1'b0; end
                else begin m0_read = 1'b0; m0_write = 1'b0; end
            end else if (bus_read || bus_write) begin
                strobes++;
                if (strobes == 1) begin
                    check_output($sformatf("v%0d_owner", idx), owner, v.exp_owner);
                    check_output($sformatf("v%0d_write", idx), bus_write, v.exp_wr);
                    check_output($sformatf("v%0d_read", idx), bus_read, !v.exp_wr);
                    check_output($sformatf("v%0d_address", idx), address, v.exp_addr);
                    check_output($sformatf("v%0d_wdata", idx), slave_wdata, v.exp_wd);
                    check_output($sformatf("v%0d_busy", idx), busy, 1);
                end
                if (v.latency >= 0 && strobes == v.latency + 1) begin
                    data_valid  = 1'b1;
                    slave_rdata = v.slave_rd;
                end
            end
        end
        if (!got_ack) check_output($sformatf("v%0d_ack_seen", idx), 0, 1);
        @(negedge clock);
        check_output($sformatf("v%0d_ack_pulse", idx), {m0_ack, m1_ack, error}, 0);
    endtask

    vec_t vecs[8];
    vec_t tie_vec;
    int   order[$];
    int   ack_cycles;

    initial begin
        vecs[0] = '{1, 0, 16'h8000, 8'h11, 0, 0, 16'h0000, 8'h00, 2, 8'hA9, 0, 0, 16'h8000, 8'h11, 3, 8'hA9, 0};
        vecs[1] = '{0, 0, 16'h0000, 8'h00, 0, 1, 16'h0200, 8'h5C, 0, 8'hEE, 1, 1, 16'h0200, 8'h5C, 1, 8'h00, 0};
        vecs[2] = '{1, 0, 16'h1000, 8'h21, 1, 0, 16'h2000, 8'h22, 1, 8'hB1, 0, 0, 16'h1000, 8'h21, 2, 8'hB1, 0};
        vecs[3] = '{1, 0, 16'h1000, 8'h21, 1, 0, 16'h2000, 8'h22, 1, 8'hB2, 1, 0, 16'h2000, 8'h22, 2, 8'hB2, 0};
        vecs[4] = '{1, 0, 16'h1000, 8'h21, 1, 0, 16'h2000, 8'h22, 1, 8'hB3, 0, 0, 16'h1000, 8'h21, 2, 8'hB3, 0};
        vecs[5] = '{1, 0, 16'h1000, 8'h21, 1, 0, 16'h2000, 8'h22, 1, 8'hB4, 1, 0, 16'h2000, 8'h22, 2, 8'hB4, 0};
        vecs[6] = '{1, 1, 16'h3000, 8'h77, 0, 0, 16'h0000, 8'h00, 0, 8'hEE, 0, 1, 16'h3000, 8'h77, 1, 8'h00, 0};
        vecs[7] = '{1, 0, 16'h4000, 8'h00, 0, 0, 16'h0000, 8'h00, 4, 8'h3C, 0, 0, 16'h4000, 8'h00, 5, 8'h3C, 0};
        tie_vec = '{1, 0, 16'h6000, 8'h61, 1, 0, 16'h7000, 8'h71, 1, 8'hC6, 0, 0, 16'h6000, 8'h61, 2, 8'hC6, 0};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_output("reset_strobes", {bus_read, bus_write}, 0);
        check_output("reset_address", address, 0);
        check_output("reset_wdata", slave_wdata, 0);
        check_output("reset_acks", {m0_ack, m1_ack}, 0);
        check_output("reset_mdata", {m0_rdata, m1_rdata}, 0);
        check_output("reset_owner_busy_err", {owner, busy, error}, 0);

        for (int i = 0; i < 8; i++) apply_stimulus(i, vecs[i]);

        // Reset in the middle of a read: strobe must fall without waiting for a clock and no ack follows.
        m0_read = 1'b1; m0_address = 16'h5000;
        @(negedge clock);
        check_output("rst_pre_strobe", bus_read, 1);
        #2 reset = 1'b1;
        #1;
        check_output("rst_strobe_drop", {bus_read, bus_write, busy}, 0);
        m0_read = 1'b0;
        data_valid = 1'b1;
        slave_rdata = 8'hDD;
        @(negedge clock);
        data_valid = 1'b0;
        reset = 1'b0;
        ack_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (m0_ack || m1_ack || busy) ack_cycles++;
        end
        check_output("rst_no_ack", ack_cycles, 0);
        apply_stimulus(8, tie_vec);
        m1_read = 1'b0;

`ifdef BUS_ARBITER_TIMEOUT_EN
        apply_stimulus(9, '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0300, 8'h00, -1, 8'h00, 1, 0, 16'h0300, 8'h00, 8, 8'hFF, 1});
        apply_stimulus(10, '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0301, 8'h00, 7, 8'h42, 1, 0, 16'h0301, 8'h00, 8, 8'h42, 0});
`endif

        // Fixed priority: m0 keeps re-requesting for four transactions before m1 ever wins.
        begin
            int  m0_done = 0;
            bit  reraise = 0;
            f_m0_read = 1'b1;
            f_m1_read = 1'b1;
            for (int cyc = 0; cyc < 100 && order.size() < 5; cyc++) begin
                @(negedge clock);
                if (f_m0_ack) begin
                    order.push_back(0);
                    f_m0_read = 1'b0;
                    m0_done++;
                    reraise = (m0_done < 4);
                end else if (f_m1_ack) begin
                    order.push_back(1);
                    f_m1_read = 1'b0;
                end else if (reraise) begin
                    f_m0_read = 1'b1;
                    reraise = 0;
                end
            end
            f_m0_read = 1'b0;
            f_m1_read = 1'b0;
            check_output("fixed_grant_count", order.size(), 5);
            for (int i = 0; i < 5; i++) begin
                check_output($sformatf("fixed_grant_%0d", i), (i < order.size()) ? order[i] : 32'hBAD, (i < 4) ? 0 : 1);
            end
            check_output("fixed_m1_data", f_m1_rdata, 8'h5A);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
